// File: rtl/ram_tdp_sync.sv
// rtl/ram_tdp_sync.sv - true dual-port synchronous RAM, byte enables, collision flag
// Define RAM_TDP_OUTREG_EN to add an output register stage per port (read latency 2).
module ram_tdp_sync #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int DEPTH_LOG = $clog2(DEPTH),
   parameter int READ_MODE = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en_a,
   input  logic                 we_a,
   input  logic [WIDTH/8-1:0]   be_a,
   input  logic [DEPTH_LOG-1:0] addr_a,
   input  logic [WIDTH-1:0]     wdata_a,
   output logic [WIDTH-1:0]     rdata_a,
   output logic                 rvalid_a,
   input  logic                 en_b,
   input  logic                 we_b,
   input  logic [WIDTH/8-1:0]   be_b,
   input  logic [DEPTH_LOG-1:0] addr_b,
   input  logic [WIDTH-1:0]     wdata_b,
   output logic [WIDTH-1:0]     rdata_b,
   output logic                 rvalid_b,
   output logic                 collision
);
   localparam int NB = WIDTH / 8;

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic             in_a, in_b, wr_a, wr_b, same_ww, coll_d;
   logic [WIDTH-1:0] old_a, old_b, mrg_a, mrg_b, mrg_ab;
   logic [WIDTH-1:0] rdata_a_d, rdata_b_d, rdata_a_q, rdata_b_q;
   logic             rvalid_a_q, rvalid_b_q, coll_q;

   always_comb begin
      in_a    = int'(addr_a) < DEPTH;
      in_b    = int'(addr_b) < DEPTH;
      old_a   = in_a ? mem_q[addr_a] : '0;
      old_b   = in_b ? mem_q[addr_b] : '0;
      wr_a    = rst_n & en_a & we_a & in_a & (|be_a);
      wr_b    = rst_n & en_b & we_b & in_b & (|be_b);
      same_ww = wr_a & wr_b & (addr_a == addr_b);
      coll_d  = en_a & en_b & (addr_a == addr_b) & (we_a | we_b);
   end

   // mrg_ab is only used when both ports write one word, so old_a == old_b there
   always_comb begin
      mrg_a  = '0;
      mrg_b  = '0;
      mrg_ab = '0;
      for (int i = 0; i < NB; i++) begin
         mrg_a[8*i +: 8]  = be_a[i] ? wdata_a[8*i +: 8] : old_a[8*i +: 8];
         mrg_b[8*i +: 8]  = be_b[i] ? wdata_b[8*i +: 8] : old_b[8*i +: 8];
         mrg_ab[8*i +: 8] = be_a[i] ? wdata_a[8*i +: 8] : mrg_b[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_a) mem_q[addr_a] <= same_ww ? mrg_ab : mrg_a;
      if (wr_b && !same_ww) mem_q[addr_b] <= mrg_b;
   end

   always_comb begin
      rdata_a_d = rdata_a_q;
      if (en_a) begin
         if (!in_a)                        rdata_a_d = '0;
         else if (we_a && READ_MODE == 1)  rdata_a_d = mrg_a;
         else if (we_a && READ_MODE == 2)  rdata_a_d = rdata_a_q;
         else                              rdata_a_d = old_a;
      end
   end

   always_comb begin
      rdata_b_d = rdata_b_q;
      if (en_b) begin
         if (!in_b)                        rdata_b_d = '0;
         else if (we_b && READ_MODE == 1)  rdata_b_d = mrg_b;
         else if (we_b && READ_MODE == 2)  rdata_b_d = rdata_b_q;
         else                              rdata_b_d = old_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_a_q  <= '0;
         rdata_b_q  <= '0;
         rvalid_a_q <= 1'b0;
         rvalid_b_q <= 1'b0;
         coll_q     <= 1'b0;
      end else begin
         rdata_a_q  <= rdata_a_d;
         rdata_b_q  <= rdata_b_d;
         rvalid_a_q <= en_a;
         rvalid_b_q <= en_b;
         coll_q     <= coll_d;
      end
   end

`ifdef RAM_TDP_OUTREG_EN
   logic [WIDTH-1:0] rdata_a_o_q, rdata_b_o_q;
   logic             rvalid_a_o_q, rvalid_b_o_q, coll_o_q;

   // The final stage only loads on a valid beat so idle cycles hold the last read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_a_o_q  <= '0;
         rdata_b_o_q  <= '0;
         rvalid_a_o_q <= 1'b0;
         rvalid_b_o_q <= 1'b0;
         coll_o_q     <= 1'b0;
      end else begin
         if (rvalid_a_q) rdata_a_o_q <= rdata_a_q;
         if (rvalid_b_q) rdata_b_o_q <= rdata_b_q;
         rvalid_a_o_q <= rvalid_a_q;
         rvalid_b_o_q <= rvalid_b_q;
         coll_o_q     <= coll_q;
      end
   end

   assign rdata_a   = rdata_a_o_q;
   assign rdata_b   = rdata_b_o_q;
   assign rvalid_a  = rvalid_a_o_q;
   assign rvalid_b  = rvalid_b_o_q;
   assign collision = coll_o_q;
`else
   assign rdata_a   = rdata_a_q;
   assign rdata_b   = rdata_b_q;
   assign rvalid_a  = rvalid_a_q;
   assign rvalid_b  = rvalid_b_q;
   assign collision = coll_q;
`endif

endmodule

// File: tb/tb_ram_tdp_sync.sv
// tb/tb_ram_tdp_sync.sv - self-checking bench for ram_tdp_sync
// Three instances (READ_FIRST, WRITE_FIRST, NO_CHANGE) share one stimulus stream.
module tb_ram_tdp_sync;
   localparam int W  = 32;
   localparam int D  = 12;
   localparam int AW = $clog2(D);
`ifdef RAM_TDP_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam int NV = 19;

   typedef struct {
      logic ea; logic wa; logic [3:0] ba; logic [AW-1:0] aa; logic [W-1:0] da;
      logic eb; logic wb; logic [3:0] bb; logic [AW-1:0] ab; logic [W-1:0] db;
      logic ka; logic [W-1:0] xa;
      logic kb; logic [W-1:0] xb;
      logic xc;
   } vec_t;

   typedef struct {
      int idx;
      logic va; logic ka; logic [W-1:0] xa;
      logic vb; logic kb; logic [W-1:0] xb;
      logic xc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en_a, we_a, en_b, we_b;
   logic [3:0]    be_a, be_b;
   logic [AW-1:0] addr_a, addr_b;
   logic [W-1:0]  wdata_a, wdata_b;
   logic [W-1:0]  rd_a [3];
   logic [W-1:0]  rd_b [3];
   logic          rv_a [3];
   logic          rv_b [3];
   logic          col  [3];

   int   nvec = 0;
   int   nerr = 0;
   vec_t tbl [NV];
   exp_t q [$];

   always #5 clk = ~clk;

   for (genvar m = 0; m < 3; m++) begin : g_dut
      ram_tdp_sync #(.WIDTH(W), .DEPTH(D), .READ_MODE(m)) u_dut (
         .clk(clk), .rst_n(rst_n),
         .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wdata_a(wdata_a),
         .rdata_a(rd_a[m]), .rvalid_a(rv_a[m]),
         .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wdata_b(wdata_b),
         .rdata_b(rd_b[m]), .rvalid_b(rv_b[m]),
         .collision(col[m])
      );
   end

   function automatic vec_t v(input logic ea, wa, input logic [3:0] ba, input logic [AW-1:0] aa,
                              input logic [W-1:0] da, input logic eb, wb, input logic [3:0] bb,
                              input logic [AW-1:0] ab, input logic [W-1:0] db,
                              input logic ka, input logic [W-1:0] xa,
                              input logic kb, input logic [W-1:0] xb, input logic xc);
      vec_t r;
      r.ea = ea; r.wa = wa; r.ba = ba; r.aa = aa; r.da = da;
      r.eb = eb; r.wb = wb; r.bb = bb; r.ab = ab; r.db = db;
      r.ka = ka; r.xa = xa; r.kb = kb; r.xb = xb; r.xc = xc;
      return r;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      nvec++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic idle();
      en_a = 0; we_a = 0; be_a = 0; addr_a = 0; wdata_a = 0;
      en_b = 0; we_b = 0; be_b = 0; addr_b = 0; wdata_b = 0;
   endtask

   task automatic drive(input vec_t t);
      en_a = t.ea; we_a = t.wa; be_a = t.ba; addr_a = t.aa; wdata_a = t.da;
      en_b = t.eb; we_b = t.wb; be_b = t.bb; addr_b = t.ab; wdata_b = t.db;
   endtask

   // One access, then idle until its result has reached the outputs
   task automatic access(input vec_t t);
      drive(t);
      @(posedge clk); #1;
      idle();
      repeat (LAT - 1) @(posedge clk);
      if (LAT > 1) #1;
   endtask

   task automatic compare(input exp_t e);
      chk($sformatf("v%0d rvalid_a", e.idx), W'(rv_a[0]), W'(e.va));
      chk($sformatf("v%0d rvalid_b", e.idx), W'(rv_b[0]), W'(e.vb));
      chk($sformatf("v%0d collision", e.idx), W'(col[0]), W'(e.xc));
      if (e.ka) chk($sformatf("v%0d rdata_a", e.idx), rd_a[0], e.xa);
      if (e.kb) chk($sformatf("v%0d rdata_b", e.idx), rd_b[0], e.xb);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      exp_t e;
      vec_t t;
      //            A: en we be addr data          B: en we be addr data           chkA expA        chkB expB         coll
      tbl[0]  = v(1,1,4'hF, 0,32'h0000_0A0A,  1,1,4'hF,11,32'hB0B0_0011,  0,0,            0,0,            0);
      tbl[1]  = v(1,1,4'hF, 3,32'hDEAD_BEEF,  1,1,4'hF, 5,32'h0000_00AA,  0,0,            0,0,            0);
      tbl[2]  = v(1,1,4'hF, 2,32'h0000_000F,  1,1,4'hF, 7,32'h0000_0099,  0,0,            0,0,            0);
      tbl[3]  = v(1,1,4'h5, 3,32'h1122_3344,  1,0,4'h0, 3,32'h0,          1,32'hDEAD_BEEF,1,32'hDEAD_BEEF,1);
      tbl[4]  = v(1,0,4'h0, 3,32'h0,          1,0,4'h0, 3,32'h0,          1,32'hDE22_BE44,1,32'hDE22_BE44,0);
      tbl[5]  = v(1,1,4'hF, 7,32'h0000_0012,  1,1,4'hF, 7,32'h0000_0034,  1,32'h0000_0099,1,32'h0000_0099,1);
      tbl[6]  = v(1,0,4'h0, 7,32'h0,          0,0,4'h0, 0,32'h0,          1,32'h0000_0012,1,32'h0000_0099,0);
      tbl[7]  = v(1,1,4'hF, 2,32'h0000_00F0,  1,0,4'h0, 2,32'h0,          1,32'h0000_000F,1,32'h0000_000F,1);
      tbl[8]  = v(0,0,4'h0, 0,32'h0,          1,0,4'h0, 2,32'h0,          1,32'h0000_000F,1,32'h0000_00F0,0);
      tbl[9]  = v(1,1,4'hF,13,32'hFFFF_FFFF,  1,0,4'h0,13,32'h0,          1,32'h0,        1,32'h0,        1);
      tbl[10] = v(1,0,4'h0,13,32'h0,          1,0,4'h0,11,32'h0,          1,32'h0,        1,32'hB0B0_0011,0);
      tbl[11] = v(1,0,4'h0, 0,32'h0,          1,0,4'h0,11,32'h0,          1,32'h0000_0A0A,1,32'hB0B0_0011,0);
      tbl[12] = v(1,0,4'h0,11,32'h0,          1,0,4'h0, 0,32'h0,          1,32'hB0B0_0011,1,32'h0000_0A0A,0);
      tbl[13] = v(1,0,4'h0, 0,32'h0,          1,0,4'h0,11,32'h0,          1,32'h0000_0A0A,1,32'hB0B0_0011,0);
      tbl[14] = v(1,1,4'h0, 0,32'hFFFF_FFFF,  1,0,4'h0, 0,32'h0,          1,32'h0000_0A0A,1,32'h0000_0A0A,1);
      tbl[15] = v(1,0,4'h0, 0,32'h0,          1,1,4'h8, 0,32'h7700_0000,  1,32'h0000_0A0A,1,32'h0000_0A0A,1);
      tbl[16] = v(1,0,4'h0, 0,32'h0,          0,0,4'h0, 0,32'h0,          1,32'h7700_0A0A,1,32'h0000_0A0A,0);
      tbl[17] = v(0,0,4'h0, 0,32'h0,          0,0,4'h0, 0,32'h0,          1,32'h7700_0A0A,1,32'h0000_0A0A,0);
      tbl[18] = v(1,0,4'h0, 5,32'h0,          1,0,4'h0, 3,32'h0,          1,32'h0000_00AA,1,32'hDE22_BE44,0);

      idle();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset rdata_a", rd_a[0], 32'h0);
      chk("reset rdata_b", rd_b[0], 32'h0);
      chk("reset rvalid_a", W'(rv_a[0]), 32'h0);
      chk("reset rvalid_b", W'(rv_b[0]), 32'h0);
      chk("reset collision", W'(col[0]), 32'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < NV; i++) begin
         drive(tbl[i]);
         e.idx = i;
         e.va = tbl[i].ea; e.ka = tbl[i].ka; e.xa = tbl[i].xa;
         e.vb = tbl[i].eb; e.kb = tbl[i].kb; e.xb = tbl[i].xb;
         e.xc = tbl[i].xc;
         q.push_back(e);
         @(posedge clk); #1;
         if (q.size() == LAT) compare(q.pop_front());
      end
      idle();
      while (q.size() > 0) begin
         @(posedge clk); #1;
         compare(q.pop_front());
      end

      // Same-port read-during-write in each mode
      t = v(1,0,4'h0,3,32'h0, 0,0,4'h0,0,32'h0, 0,0,0,0,0);
      access(t);
      chk("nc pre-read rdata_a", rd_a[2], 32'hDE22_BE44);
      t = v(1,1,4'hF,5,32'h0000_0055, 0,0,4'h0,0,32'h0, 0,0,0,0,0);
      access(t);
      chk("rf rdw rdata_a", rd_a[0], 32'h0000_00AA);
      chk("wf rdw rdata_a", rd_a[1], 32'h0000_0055);
      chk("nc rdw rdata_a", rd_a[2], 32'hDE22_BE44);
      chk("nc rdw rvalid_a", W'(rv_a[2]), 32'h1);
      t = v(1,0,4'h0,5,32'h0, 0,0,4'h0,0,32'h0, 0,0,0,0,0);
      access(t);
      chk("readback addr5", rd_a[0], 32'h0000_0055);
      t = v(1,1,4'h3,3,32'h0000_7788, 0,0,4'h0,0,32'h0, 0,0,0,0,0);
      access(t);
      chk("rf partial rdw", rd_a[0], 32'hDE22_BE44);
      chk("wf partial rdw", rd_a[1], 32'hDE22_7788);
      chk("nc partial rdw", rd_a[2], 32'h0000_0055);

      // Asynchronous reset with a valid beat on the outputs
      t = v(1,0,4'h0,3,32'h0, 0,0,4'h0,0,32'h0, 0,0,0,0,0);
      access(t);
      chk("pre-reset rvalid_a", W'(rv_a[0]), 32'h1);
      chk("pre-reset rdata_a", rd_a[0], 32'hDE22_7788);
      rst_n = 1'b0;
      #1;
      chk("async rst rdata_a", rd_a[0], 32'h0);
      chk("async rst rdata_b", rd_b[0], 32'h0);
      chk("async rst rvalid_a", W'(rv_a[0]), 32'h0);
      chk("async rst rvalid_b", W'(rv_b[0]), 32'h0);
      chk("async rst collision", W'(col[0]), 32'h0);
      t = v(1,1,4'hF,3,32'hFFFF_FFFF, 1,0,4'h0,3,32'h0, 0,0,0,0,0);
      drive(t);
      @(posedge clk); #1;
      chk("in-reset rvalid_a", W'(rv_a[0]), 32'h0);
      chk("in-reset rvalid_b", W'(rv_b[0]), 32'h0);
      idle();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      t = v(1,0,4'h0,3,32'h0, 1,0,4'h0,5,32'h0, 0,0,0,0,0);
      access(t);
      chk("post-reset rdata_a", rd_a[0], 32'hDE22_7788);
      chk("post-reset rdata_b", rd_b[0], 32'h0000_0055);
      chk("post-reset rvalid_a", W'(rv_a[0]), 32'h1);
      chk("post-reset rvalid_b", W'(rv_b[0]), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/ram_tdp_sync.md
Name: ram_tdp_sync

Overview:
- Parametrised true dual-port RAM with two symmetric ports, A and B.
- Each port can independently read or write on every cycle.
- Features: per-byte write enables, selectable same-port read-during-write mode, registered synchronous reads with a valid strobe, and a same-address collision flag.
- Successor to the team's single-write/single-read dual-port RAM; used as the shared buffer between two independent masters in one clock domain.

Parameters:
- WIDTH, 8: data word width in bits; must be a multiple of 8.
- DEPTH, 16: number of words; any value ≥2, not required to be a power of two.
- DEPTH_LOG, $clog2(DEPTH): address width.
- READ_MODE, 0: same-port read-during-write behaviour. 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en_a  input  1  port A access enable.
- we_a  input  1  port A write enable, active-high; qualified by en_a.
- be_a  input  WIDTH/8  port A byte enables; bit i covers data bits [8i+7:8i].
- addr_a  input  DEPTH_LOG  port A word address.
- wdata_a  input  WIDTH  port A write data.
- rdata_a  output  WIDTH  port A read data.
- rvalid_a  output  1  port A read data valid strobe.
- en_b, we_b, be_b, addr_b, wdata_b, rdata_b, rvalid_b: identical to port A, for port B.
- collision  output  1  one-cycle pulse when both ports hit the same address in a cycle and at least one is writing.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rdata_a, rdata_b, rvalid_a, rvalid_b, collision and all pipeline registers go to 0 immediately.
  - Memory contents are NOT cleared.
  - On deassertion, normal operation resumes at the next rising edge.
  - An access presented in the same cycle reset is asserted is discarded: no write, no rvalid.
- Write:
  - Occurs when en_x=1, we_x=1 and addr_x<DEPTH.
  - Only bytes with be_x[i]=1 are updated; be_x=0 performs no write.
- Read:
  - Every cycle with en_x=1 is a read access, including write cycles.
  - Base latency is 1 cycle: rdata_x and rvalid_x update on the edge after the access.
  - rvalid_x is 1 for exactly one cycle per access.
  - When en_x=0, rdata_x holds its last value and rvalid_x=0.
- Out-of-range address (addr_x ≥ DEPTH): write ignored; read returns 0 with rvalid asserted.
- Same-port read-during-write (en_x=we_x=1):
  - READ_FIRST: rdata_x = word contents before the write.
  - WRITE_FIRST: rdata_x = merged new word (written bytes new, unwritten bytes old).
  - NO_CHANGE: rdata_x holds its previous value; rvalid_x is still asserted.
- Cross-port, same address, same cycle:
  - One port writes, other reads: the reader gets the OLD word in all modes.
  - Both write: per byte, A wins where be_a[i]=1; B's byte is applied only where be_a[i]=0 and be_b[i]=1.
- Collision flag:
  - Condition: en_a & en_b & (addr_a==addr_b) & (we_a|we_b), evaluated on the access cycle.
  - The flag is registered and aligned with the rvalid of that access cycle, at the same latency.
- Ports are fully independent; there is no arbitration and no backpressure.

Optional Feature:
- Macro: RAM_TDP_OUTREG_EN.
- Defined: an extra output register stage per port.
  - Read latency becomes 2 cycles.
  - rdata_x, rvalid_x and collision are each delayed one further cycle.
  - The extra stage is cleared by rst_n.
  - The hold-when-idle rule applies at the final stage.
- Undefined: latency is 1 cycle as specified above.

Test Plan:
- Reset values: assert rst_n=0 mid-run with rvalid_a=1 → rdata_a, rdata_b, rvalid_a, rvalid_b and collision all read 0 within the same cycle. Memory written before reset still reads back its old values afterwards.
- Byte enables: WIDTH=32. Write A addr 3 = 0xDEADBEEF with be=1111, then write A addr 3 = 0x11223344 with be=0101. B reads addr 3 → 0xDE22BE44 one cycle later (two cycles with the macro defined).
- Read-during-write modes: addr 5 holds 0xAA; port A writes 0x55 to addr 5 with en=we=1.
  - READ_FIRST → rdata_a=0xAA.
  - WRITE_FIRST → rdata_a=0x55.
  - NO_CHANGE → rdata_a unchanged, rvalid_a=1.
- Write-write collision: same cycle, A writes 0x12 and B writes 0x34 to addr 7, full byte enables → collision pulses for one cycle and a later read of addr 7 returns 0x12.
- Cross-port read during write: addr 2 holds 0x0F; A writes 0xF0 to addr 2 while B reads addr 2 → rdata_b=0x0F and collision=1. Reading again next cycle → rdata_b=0xF0 and collision=0.
- Boundaries: DEPTH=12, write to addr 13 → no change to memory, read of addr 13 returns 0. Back-to-back reads of addr 0 and addr 11 every cycle → rvalid stays high continuously with correct data, with no gaps.
